// File: rtl/draw_arbiter.sv
// Purpose : round-robin arbiter funnelling NUM_REQ pixel streams into one vga write port, one stream per grant, once per frame.
// Latency : accepted pixel appears on write_* one cycle after accept; one idle cycle between consecutive streams.
// Backpres: req_ready is high only for the granted requester in DRAW while rst_screen_33m is low; requesters hold data until accepted.
//
// Ports:
//   clk_33m, rst              clock, asynchronous active-high reset
//   rst_screen_33m            frame-swap level from vga (rising edge = swap event)
//   req_valid/req_last        per-requester valid and end-of-stream marker
//   req_x/req_y/req_palette   packed per-requester pixel data, lane i at [i*W +: W]
//   req_ready                 per-requester accept
//   write_x/y/palette         registered write port, palette 0 = no write
//   frame_count               swap counter (8-bit wrap)
//   busy                      DRAW with a grant held
//   overrun                   one-cycle pulse when a swap aborts an unfinished stream
module draw_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int COOR_WIDTH = 12,
  parameter int FRAME_W    = 1280,
  parameter int FRAME_H    = 300
) (
  input  logic                          clk_33m,
  input  logic                          rst,
  input  logic                          rst_screen_33m,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*COOR_WIDTH-1:0] req_x,
  input  logic [NUM_REQ*COOR_WIDTH-1:0] req_y,
  input  logic [NUM_REQ*2-1:0]          req_palette,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [COOR_WIDTH-1:0]         write_x,
  output logic [COOR_WIDTH-1:0]         write_y,
  output logic [1:0]                    write_palette,
  output logic [7:0]                    frame_count,
  output logic                          busy,
  output logic                          overrun
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    grant_vld_q, grant_vld_d;
  logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
  logic [NUM_REQ-1:0]      served_q, served_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [COOR_WIDTH-1:0]   write_x_q, write_x_d;
  logic [COOR_WIDTH-1:0]   write_y_q, write_y_d;
  logic [1:0]              write_pal_q, write_pal_d;
  logic [7:0]              frame_count_q, frame_count_d;
  logic                    overrun_q, overrun_d;
  logic                    swap_prev_q, swap_prev_d;

  logic                    swap;
  logic                    grant_active;
  logic                    accept;
  logic [COOR_WIDTH-1:0]   sel_x, sel_y;
  logic [1:0]              sel_pal;
  logic                    sel_valid, sel_last;
  logic                    in_range;
  logic                    pick_found;
  logic [IDX_W-1:0]        pick_idx;
  logic [IDX_W-1:0]        cand_idx;

  // Indices never exceed 2*NUM_REQ-2, so one conditional subtract wraps them.
  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    int w;
    w = v;
    if (w >= NUM_REQ) w = w - NUM_REQ;
    return IDX_W'(w);
  endfunction

  assign swap         = rst_screen_33m & ~swap_prev_q;
  assign grant_active = (state_q == ST_DRAW) & grant_vld_q & ~rst_screen_33m;

  // Lane mux for the currently granted requester.
  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    sel_pal   = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_q == IDX_W'(i)) begin
        sel_x     = req_x[i*COOR_WIDTH +: COOR_WIDTH];
        sel_y     = req_y[i*COOR_WIDTH +: COOR_WIDTH];
        sel_pal   = req_palette[i*2 +: 2];
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_active & (grant_idx_q == IDX_W'(i));
    end
  end

  assign accept   = grant_active & sel_valid;
  assign in_range = (int'(sel_x) < FRAME_W) && (int'(sel_y) < FRAME_H);

  // Round-robin search from rr_ptr upward; walking backwards lets the
  // nearest candidate overwrite farther ones.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    cand_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_idx = wrap_idx(int'(rr_ptr_q) + k);
      if (req_valid[cand_idx] & ~served_q[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_vld_d   = grant_vld_q;
    grant_idx_d   = grant_idx_q;
    served_d      = served_q;
    rr_ptr_d      = rr_ptr_q;
    frame_count_d = frame_count_q;
    overrun_d     = 1'b0;
    swap_prev_d   = rst_screen_33m;
    write_x_d     = write_x_q;
    write_y_d     = write_y_q;
    write_pal_d   = 2'd0;

    if (accept) begin
      write_x_d   = sel_x;
      write_y_d   = sel_y;
      write_pal_d = in_range ? sel_pal : 2'd0;
    end

    if (swap) begin
      // A swap restarts the frame from any state; an open stream is aborted
      // without marking it served, and rr_ptr is left where it was.
      state_d       = ST_DRAW;
      served_d      = '0;
      grant_vld_d   = 1'b0;
      frame_count_d = frame_count_q + 8'd1;
      overrun_d     = (state_q == ST_DRAW) & grant_vld_q;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_DRAW: begin
          if (grant_vld_q) begin
            if (accept && sel_last) begin
              served_d[grant_idx_q] = 1'b1;
              grant_vld_d           = 1'b0;
              rr_ptr_d              = wrap_idx(int'(grant_idx_q) + 1);
              if (&served_d) state_d = ST_DONE;
            end
          end else if (pick_found) begin
            // Selection only happens with no grant held, which forces the
            // idle cycle between streams.
            grant_vld_d = 1'b1;
            grant_idx_d = pick_idx;
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_33m or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_vld_q   <= 1'b0;
      grant_idx_q   <= '0;
      served_q      <= '0;
      rr_ptr_q      <= '0;
      write_x_q     <= '0;
      write_y_q     <= '0;
      write_pal_q   <= 2'd0;
      frame_count_q <= 8'd0;
      overrun_q     <= 1'b0;
      swap_prev_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_vld_q   <= grant_vld_d;
      grant_idx_q   <= grant_idx_d;
      served_q      <= served_d;
      rr_ptr_q      <= rr_ptr_d;
      write_x_q     <= write_x_d;
      write_y_q     <= write_y_d;
      write_pal_q   <= write_pal_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
      swap_prev_q   <= swap_prev_d;
    end
  end

  assign write_x       = write_x_q;
  assign write_y       = write_y_q;
  assign write_palette = write_pal_q;
  assign frame_count   = frame_count_q;
  assign overrun       = overrun_q;
  assign busy          = (state_q == ST_DRAW) & grant_vld_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed bench for draw_arbiter: reset, single stream, round-robin order,
// overrun on swap, range clipping, held swap level, counter wrap, async reset.
module tb_draw_arbiter;

  localparam int NR = 4;
  localparam int CW = 12;

  logic            clk_33m = 1'b0;
  logic            rst = 1'b1;
  logic            rst_screen_33m = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_last = '0;
  logic [NR*CW-1:0] req_x = '0;
  logic [NR*CW-1:0] req_y = '0;
  logic [NR*2-1:0] req_palette = '0;
  logic [NR-1:0]   req_ready;
  logic [CW-1:0]   write_x, write_y;
  logic [1:0]      write_palette;
  logic [7:0]      frame_count;
  logic            busy, overrun;

  int total = 0;
  int bad = 0;

  draw_arbiter #(.NUM_REQ(NR), .COOR_WIDTH(CW), .FRAME_W(1280), .FRAME_H(300)) dut (
    .clk_33m(clk_33m), .rst(rst), .rst_screen_33m(rst_screen_33m),
    .req_valid(req_valid), .req_last(req_last),
    .req_x(req_x), .req_y(req_y), .req_palette(req_palette),
    .req_ready(req_ready), .write_x(write_x), .write_y(write_y),
    .write_palette(write_palette), .frame_count(frame_count),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk_33m = ~clk_33m;

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk_33m);
    #1;
  endtask

  task automatic set_lane(input int i, input int x, input int y, input int p, input bit last);
    req_x[i*CW +: CW]     = CW'(x);
    req_y[i*CW +: CW]     = CW'(y);
    req_palette[i*2 +: 2] = 2'(p);
    req_last[i]           = last;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    total++; if ({write_x, write_y, write_palette} !== 26'd0) begin bad++; $display("FAIL reset_write got=%0d/%0d/%0d want=0/0/0", write_x, write_y, write_palette); end
    total++; if (frame_count !== 8'd0) begin bad++; $display("FAIL reset_fc got=%0d want=0", frame_count); end
    total++; if ({busy, overrun} !== 2'b00) begin bad++; $display("FAIL reset_busy_ovr got=%b want=00", {busy, overrun}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_stream();
    req_valid = 4'b0001;
    set_lane(0, 5, 7, 2, 1'b0);
    tick();
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL idle_ready got=%b want=0000", req_ready); end
    rst_screen_33m = 1'b1;
    tick();
    total++; if (frame_count !== 8'd1) begin bad++; $display("FAIL single_fc got=%0d want=1", frame_count); end
    tick();
    rst_screen_33m = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b want=0001", req_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", busy); end
    tick();
    total++; if ({write_x, write_y, write_palette} !== {12'd5, 12'd7, 2'd2}) begin bad++; $display("FAIL single_px0 got=%0d,%0d,%0d want=5,7,2", write_x, write_y, write_palette); end
    set_lane(0, 6, 7, 3, 1'b0);
    tick();
    total++; if ({write_x, write_y, write_palette} !== {12'd6, 12'd7, 2'd3}) begin bad++; $display("FAIL single_px1 got=%0d,%0d,%0d want=6,7,3", write_x, write_y, write_palette); end
    set_lane(0, 7, 7, 1, 1'b1);
    tick();
    total++; if ({write_x, write_y, write_palette} !== {12'd7, 12'd7, 2'd1}) begin bad++; $display("FAIL single_px2 got=%0d,%0d,%0d want=7,7,1", write_x, write_y, write_palette); end
    // Requester 0 is served: it stays valid but must not be granted again.
    tick();
    tick();
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_served got=%b want=0000", req_ready); end
    total++; if (write_palette !== 2'd0) begin bad++; $display("FAIL single_nowrite got=%0d want=0", write_palette); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b want=0", busy); end
    total++; if (frame_count !== 8'd1) begin bad++; $display("FAIL single_fc_end got=%0d want=1", frame_count); end
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < NR; i++) set_lane(i, 100 + i, 0, ((i % 3) + 1), 1'b0);
    req_valid = 4'b1111;
    rst_screen_33m = 1'b1;
    tick();
    rst_screen_33m = 1'b0;
    tick();
    for (int g = 0; g < NR; g++) begin
      exp_rdy = 4'b0001 << g;
      for (int k = 0; k < 2; k++) begin
        set_lane(g, 100 + g, k, ((g + k) % 3) + 1, (k == 1));
        #1;
        total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_ready g=%0d k=%0d got=%b want=%b", g, k, req_ready, exp_rdy); end
        tick();
        total++; if (write_x !== CW'(100 + g) || write_y !== CW'(k) || write_palette !== 2'(((g + k) % 3) + 1))
          begin bad++; $display("FAIL rr_px g=%0d k=%0d got=%0d,%0d,%0d want=%0d,%0d,%0d", g, k, write_x, write_y, write_palette, 100 + g, k, ((g + k) % 3) + 1); end
      end
      total++; if (req_ready !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL rr_gap g=%0d got=%b/%b want=0000/0", g, req_ready, busy); end
      tick();
    end
    // DONE: every requester still valid, nothing granted.
    for (int n = 0; n < 3; n++) begin
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rr_done n=%0d got=%b want=0000", n, req_ready); end
      tick();
    end
    total++; if (frame_count !== 8'd1) begin bad++; $display("FAIL rr_fc got=%0d want=1", frame_count); end
  endtask

  task automatic test_overrun();
    req_valid = 4'b0100;
    set_lane(2, 40, 41, 2, 1'b0);
    rst_screen_33m = 1'b1;
    tick();
    tick();
    rst_screen_33m = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL ovr_grant got=%b want=0100", req_ready); end
    tick();
    tick();
    total++; if (frame_count !== 8'd2) begin bad++; $display("FAIL ovr_fc0 got=%0d want=2", frame_count); end
    rst_screen_33m = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL ovr_ready_drop got=%b want=0000", req_ready); end
    tick();
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse got=%b want=1", overrun); end
    total++; if (frame_count !== 8'd3) begin bad++; $display("FAIL ovr_fc1 got=%0d want=3", frame_count); end
    total++; if (write_palette !== 2'd0) begin bad++; $display("FAIL ovr_nowrite got=%0d want=0", write_palette); end
    tick();
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_pulse_end got=%b want=0", overrun); end
    rst_screen_33m = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL ovr_regrant got=%b want=0100", req_ready); end
  endtask

  task automatic test_range();
    set_lane(2, 1280, 10, 3, 1'b0);
    tick();
    total++; if ({write_x, write_y, write_palette} !== {12'd1280, 12'd10, 2'd0}) begin bad++; $display("FAIL range_x got=%0d,%0d,%0d want=1280,10,0", write_x, write_y, write_palette); end
    set_lane(2, 10, 300, 2, 1'b0);
    tick();
    total++; if ({write_x, write_y, write_palette} !== {12'd10, 12'd300, 2'd0}) begin bad++; $display("FAIL range_y got=%0d,%0d,%0d want=10,300,0", write_x, write_y, write_palette); end
    set_lane(2, 1279, 299, 1, 1'b1);
    tick();
    total++; if ({write_x, write_y, write_palette} !== {12'd1279, 12'd299, 2'd1}) begin bad++; $display("FAIL range_edge got=%0d,%0d,%0d want=1279,299,1", write_x, write_y, write_palette); end
  endtask

  task automatic test_swap_held();
    logic [7:0] fc0;
    fc0 = frame_count;
    req_valid = 4'b1111;
    rst_screen_33m = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL held_ready n=%0d got=%b want=0000", n, req_ready); end
      tick();
      total++; if (write_palette !== 2'd0) begin bad++; $display("FAIL held_nowrite n=%0d got=%0d want=0", n, write_palette); end
    end
    rst_screen_33m = 1'b0;
    total++; if (frame_count !== fc0 + 8'd1) begin bad++; $display("FAIL held_fc got=%0d want=%0d", frame_count, fc0 + 8'd1); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_fc_wrap();
    req_valid = '0;
    for (int n = 0; n < 300 && frame_count != 8'd255; n++) begin
      rst_screen_33m = 1'b1;
      tick();
      rst_screen_33m = 1'b0;
      tick();
    end
    total++; if (frame_count !== 8'd255) begin bad++; $display("FAIL wrap_reach got=%0d want=255", frame_count); end
    rst_screen_33m = 1'b1;
    tick();
    total++; if (frame_count !== 8'd0) begin bad++; $display("FAIL wrap_zero got=%0d want=0", frame_count); end
    rst_screen_33m = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    req_valid = 4'b0001;
    set_lane(0, 20, 20, 2, 1'b0);
    rst_screen_33m = 1'b1;
    tick();
    rst_screen_33m = 1'b0;
    tick();
    tick();
    total++; if (write_palette !== 2'd2 || busy !== 1'b1) begin bad++; $display("FAIL arst_pre got=%0d/%b want=2/1", write_palette, busy); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (req_ready !== 4'b0000 || busy !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL arst_ctl got=%b/%b/%b want=0000/0/0", req_ready, busy, overrun); end
    total++; if ({write_x, write_y, write_palette} !== 26'd0 || frame_count !== 8'd0) begin bad++; $display("FAIL arst_out got=%0d,%0d,%0d fc=%0d want=0,0,0 fc=0", write_x, write_y, write_palette, frame_count); end
    tick();
    tick();
    rst = 1'b0;
    for (int n = 0; n < 3; n++) tick();
    total++; if (req_ready !== 4'b0000 || write_palette !== 2'd0) begin bad++; $display("FAIL arst_quiet got=%b/%0d want=0000/0", req_ready, write_palette); end
    rst_screen_33m = 1'b1;
    tick();
    rst_screen_33m = 1'b0;
    tick();
    total++; if (req_ready !== 4'b0001 || frame_count !== 8'd1) begin bad++; $display("FAIL arst_resume got=%b fc=%0d want=0001 fc=1", req_ready, frame_count); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_round_robin();
    test_overrun();
    test_range();
    test_swap_held();
    test_fc_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/draw_arbiter.md
DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of pixel requesters.
REQ-002 Parameter COOR_WIDTH, default 12: coordinate width.
REQ-003 Parameter FRAME_W, default 1280: drawable width; x in [0, FRAME_W).
REQ-004 Parameter FRAME_H, default 300: drawable height; y in [0, FRAME_H).
REQ-005 clk_33m  in  1: sole clock; all logic on its rising edge.
REQ-006 rst  in  1: asynchronous, active-high reset.
REQ-007 rst_screen_33m  in  1: frame-swap level from vga; high for several cycles per frame.
REQ-008 req_valid  in  NUM_REQ: per-requester pixel valid.
REQ-009 req_last  in  NUM_REQ: marks requester's final pixel this frame.
REQ-010 req_x, req_y  in  NUM_REQ*COOR_WIDTH each: packed pixel coordinates, requester i at bits [i*COOR_WIDTH +: COOR_WIDTH].
REQ-011 req_palette  in  NUM_REQ*2: packed palette index, 0 = transparent.
REQ-012 req_ready  out  NUM_REQ: per-requester accept.
REQ-013 write_x, write_y  out  COOR_WIDTH; write_palette  out  2: registered write port to vga.
REQ-014 frame_count  out  8: completed-swap counter.
REQ-015 busy  out  1: high while in DRAW with a grant held.
REQ-016 overrun  out  1: one-cycle pulse on a swap that aborts an unfinished stream.

Function
REQ-017 Swap event = rising edge of rst_screen_33m, detected against a register of its previous value.
REQ-018 States: IDLE, DRAW, DONE; IDLE -> DRAW on first swap event.
REQ-019 Every swap event, in any state, SHALL enter DRAW, clear served mask, drop grant, increment frame_count (8-bit wrap).
REQ-020 In DRAW with no grant, SHALL grant the first i with req_valid[i] & ~served[i], searching from rr_ptr upward modulo NUM_REQ; grant registers one cycle after selection.
REQ-021 req_ready[i] = grant==i & state==DRAW & grant valid & !rst_screen_33m; all other ready bits 0.
REQ-022 Pixel accepted when req_valid[i] & req_ready[i]; requester SHALL hold data stable until accepted.
REQ-023 Accepted pixel appears on write_* exactly 1 cycle later; no accept in a cycle -> write_palette=0 next cycle.
REQ-024 Accepted pixel with x>=FRAME_W or y>=FRAME_H SHALL output write_palette=0 (coordinates still passed).
REQ-025 Grant held until accept with req_last[i]=1; then served[i]<=1, grant released, rr_ptr<=(i+1) mod NUM_REQ.
REQ-026 Release and next grant SHALL NOT occur same cycle: at least one idle cycle between streams.
REQ-027 served all ones -> DONE; DONE ignores req_valid until next swap event.
REQ-028 Swap event while grant held SHALL pulse overrun 1 cycle, leave served[i]=0, keep rr_ptr.
REQ-029 While rst_screen_33m high, no accepts; write_palette=0.
REQ-030 Requester never asserting req_valid never blocks others; DRAW persists until swap.

Reset
REQ-031 On rst: state IDLE, grant none, served 0, rr_ptr 0, req_ready 0, write_x/write_y/write_palette 0, frame_count 0, busy 0, overrun 0, previous-swap register 0.
REQ-032 rst asserted mid-stream SHALL abort immediately; no further writes until first swap after release.

Verification
REQ-033 Reset, then one swap pulse, req_valid=0001, three pixels (5,7,p=2)(6,7,p=3)(7,7,p=1,last) -> state DRAW, same three on write_* each 1 cycle after accept, served=0001, frame_count=1.
REQ-034 All four valid at swap, rr_ptr=0 -> grants 0,1,2,3 in order, each stream completes before next, one idle cycle between, DONE after requester 3's last.
REQ-035 Requester 2 streaming (no last) when swap arrives -> overrun pulse 1 cycle, ready drops, frame_count+1, requester 2 granted again in new frame.
REQ-036 Accepted pixel (1280,10,p=3) and (10,300,p=2) -> write_palette=0 both; (1279,299,p=1) -> write_palette=1.
REQ-037 rst_screen_33m held high 4 cycles with req_valid=1 -> req_ready=0 all 4 cycles, frame_count increments once only.
REQ-038 frame_count at 255 plus swap -> 0; rst mid-stream -> all outputs to REQ-031 values asynchronously.
